pll_drp_reconfig: RTL

Dynamic-reconfiguration (DRP) initiator for the Virtex-5 PLL_ADV primitive. It drives the DRP port (DADDR/DEN/DWE/DI, receiving DO/DRDY) and the PLL reset, which the fixed-ratio user clock wrapper ties off. It performs masked read-modify-write of PLL configuration registers, holds the PLL in reset for the duration of a write batch, releases it, then waits for LOCKED with a timeout. It sits beside the PLL, in the DRP clock domain (DCLK = CLK).

---
 rtl/pll_drp_reconfig.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig
//   DRP initiator for a PLL_ADV. Performs a masked read-modify-write of each
//   requested configuration register while holding the PLL in reset. At the
//   end of the batch it releases the reset and waits for LOCKED, with a
//   timeout on every DRP access and on the lock wait.
//
// Ports
//   CLK, RST             : clock (also the PLL DCLK), synchronous active-high reset
//   REQ_VALID/REQ_READY  : request handshake
//   REQ_ADDR/MASK/DATA   : register address, keep-mask (1 = keep old bit), new bits
//   REQ_LAST             : final word of the batch
//   DRP_DADDR/DEN/DWE/DI : DRP command
//   DRP_DO/DRP_DRDY      : DRP response
//   PLL_RST              : PLL reset, active-high
//   PLL_LOCKED           : asynchronous lock indication
//   BUSY/DONE            : not idle / one-cycle end-of-batch pulse
//   ERROR/ERR_CODE       : batch result (0 ok, 1 DRDY timeout, 2 lock timeout)
//
// state      | meaning
// S_IDLE     | waiting for the first word of a batch
// S_HOLD     | PLL held in reset before the first access
// S_RD       | read strobe
// S_WAIT_RD  | waiting for read data
// S_WR       | write strobe
// S_WAIT_WR  | waiting for write acknowledge
// S_NEXT     | waiting for the next word, PLL still in reset
// S_WAIT_LOCK| reset released, waiting for lock
module pll_drp_reconfig #(
  parameter int RST_HOLD     = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [4:0]  REQ_ADDR,
  input  logic [15:0] REQ_MASK,
  input  logic [15:0] REQ_DATA,
  input  logic        REQ_LAST,
  output logic [4:0]  DRP_DADDR,
  output logic        DRP_DEN,
  output logic        DRP_DWE,
  output logic [15:0] DRP_DI,
  input  logic [15:0] DRP_DO,
  input  logic        DRP_DRDY,
  output logic        PLL_RST,
  input  logic        PLL_LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int DW = $clog2(DRDY_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [HW-1:0] HOLD_TC = HW'(RST_HOLD);
  localparam logic [DW-1:0] DRDY_TC = DW'(DRDY_TIMEOUT);
  localparam logic [LW-1:0] LOCK_TC = LW'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RD, S_WAIT_RD, S_WR, S_WAIT_WR, S_NEXT, S_WAIT_LOCK
  } state_t;

  state_t state, state_nxt;

  logic [4:0]    addr_q;
  logic [15:0]   mask_q, data_q, wdata;
  logic          last_q;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] drdy_cnt;
  logic [LW-1:0] lock_cnt;
  logic          lock_s1, lock_s2;
  logic          accept, rd_ok, wr_ok, drdy_to, lock_ok, lock_to;

  // Address and write data are only ever changed while DEN is low, so the
  // DRP sees stable values across every strobe.
  assign DRP_DADDR = addr_q;
  assign DRP_DI    = wdata;
  assign DRP_DEN   = (state == S_RD) || (state == S_WR);
  assign DRP_DWE   = (state == S_WR);
  assign BUSY      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_ok     = 1'b0;
    wr_ok     = 1'b0;
    drdy_to   = 1'b0;
    lock_ok   = 1'b0;
    lock_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          accept    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_TC) state_nxt = S_RD;
      end
      S_RD: state_nxt = S_WAIT_RD;
      S_WAIT_RD: begin
        // A response on the expiry cycle still counts as success.
        if (DRP_DRDY) begin
          rd_ok     = 1'b1;
          state_nxt = S_WR;
        end else if (drdy_cnt == DRDY_TC) begin
          drdy_to   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WR: state_nxt = S_WAIT_WR;
      S_WAIT_WR: begin
        if (DRP_DRDY) begin
          wr_ok     = 1'b1;
          state_nxt = last_q ? S_WAIT_LOCK : S_NEXT;
        end else if (drdy_cnt == DRDY_TC) begin
          drdy_to   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_NEXT: begin
        if (REQ_VALID && REQ_READY) begin
          accept    = 1'b1;
          state_nxt = S_RD;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s2) begin
          lock_ok   = 1'b1;
          state_nxt = S_IDLE;
        end else if (lock_cnt == LOCK_TC) begin
          lock_to   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      REQ_READY <= 1'b1;
      PLL_RST   <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      ERR_CODE  <= 2'd0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      wdata     <= '0;
      hold_cnt  <= '0;
      drdy_cnt  <= '0;
      lock_cnt  <= '0;
      lock_s1   <= 1'b0;
      lock_s2   <= 1'b0;
    end else begin
      state     <= state_nxt;
      REQ_READY <= (state_nxt == S_IDLE) || (state_nxt == S_NEXT);
      DONE      <= drdy_to | lock_ok | lock_to;
      lock_s1   <= PLL_LOCKED;
      lock_s2   <= lock_s1;

      if (accept) begin
        addr_q <= REQ_ADDR;
        mask_q <= REQ_MASK;
        data_q <= REQ_DATA;
        last_q <= REQ_LAST;
      end

      // Counters start at 1 on the cycle they are armed, so reaching the
      // parameter value marks exactly that many elapsed cycles.
      if (accept && state == S_IDLE) begin
        ERROR    <= 1'b0;
        ERR_CODE <= 2'd0;
        PLL_RST  <= 1'b1;
        hold_cnt <= HW'(1);
      end else if (state == S_HOLD && hold_cnt != HOLD_TC) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (state == S_RD || state == S_WR) begin
        drdy_cnt <= DW'(1);
      end else if ((state == S_WAIT_RD || state == S_WAIT_WR) && drdy_cnt != DRDY_TC) begin
        drdy_cnt <= drdy_cnt + 1'b1;
      end

      if (rd_ok) wdata <= (DRP_DO & mask_q) | (data_q & ~mask_q);

      if (wr_ok && last_q) begin
        PLL_RST  <= 1'b0;
        lock_cnt <= LW'(1);
      end else if (state == S_WAIT_LOCK && lock_cnt != LOCK_TC) begin
        lock_cnt <= lock_cnt + 1'b1;
      end

      if (drdy_to) begin
        PLL_RST  <= 1'b0;
        ERROR    <= 1'b1;
        ERR_CODE <= 2'd1;
      end
      if (lock_to) begin
        ERROR    <= 1'b1;
        ERR_CODE <= 2'd2;
      end
    end
  end

endmodule
